// File: rtl/arm_alu_pkg.sv
// arm_alu_pkg: shared constants for the execute-stage ALU.
//   - fs function-select encodings
//   - status flag bit positions
//   - default datapath width
package arm_alu_pkg;

    localparam int ALU_WIDTH = 64;

    localparam logic [3:0] FS_AND   = 4'b0000;
    localparam logic [3:0] FS_OR    = 4'b0001;
    localparam logic [3:0] FS_ADD   = 4'b0010;
    localparam logic [3:0] FS_SUB   = 4'b0110;
    localparam logic [3:0] FS_PASSB = 4'b0111;
    localparam logic [3:0] FS_NOR   = 4'b1100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_alu_addsub.sv
// arm_alu_addsub: combinational shared adder/subtractor.
//   a, b  : operands
//   sub   : 0 -> a + b, 1 -> a + ~b + 1
//   sum   : result modulo 2^WIDTH
//   cout  : carry out of the MSB (for sub, 1 means no borrow)
//   ovf   : signed overflow
module arm_alu_addsub
    import arm_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   total;

    always_comb begin
        // Subtraction reuses the adder: invert b and inject the +1 as carry-in.
        b_eff = sub ? ~b : b;
        total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum   = total[WIDTH-1:0];
        cout  = total[WIDTH];
        // Overflow: effective operands share a sign that the result does not.
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/arm_alu.sv
// arm_alu: registered 64-bit ALU with N/Z/C/V flags, one clock of latency.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset (f=0, status=0000)
//   fs     : function select (see arm_alu_pkg)
//   a, b   : operands
//   f      : registered result
//   status : registered flags {N, Z, C, V}
module arm_alu
    import arm_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       fs,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
    output logic [3:0]       status
);

    logic [WIDTH-1:0] f_d, f_q;
    logic [3:0]       status_d, status_q;

    logic [WIDTH-1:0] as_sum;
    logic             as_cout;
    logic             as_ovf;
    logic             is_sub;
    logic             is_arith;

    assign is_sub   = (fs == FS_SUB);
    assign is_arith = (fs == FS_ADD) || (fs == FS_SUB);

    arm_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a    (a),
        .b    (b),
        .sub  (is_sub),
        .sum  (as_sum),
        .cout (as_cout),
        .ovf  (as_ovf)
    );

    always_comb begin
        f_d      = '0;
        status_d = '0;
        case (fs)
            FS_AND:   f_d = a & b;
            FS_OR:    f_d = a | b;
            FS_ADD:   f_d = as_sum;
            FS_SUB:   f_d = as_sum;
            FS_PASSB: f_d = b;
            FS_NOR:   f_d = ~(a | b);
            default:  f_d = '0;   // reserved codes yield zero, so Z=1
        endcase
        status_d[FLAG_N] = f_d[WIDTH-1];
        status_d[FLAG_Z] = (f_d == '0);
        status_d[FLAG_C] = is_arith & as_cout;
        status_d[FLAG_V] = is_arith & as_ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_q      <= '0;
            status_q <= '0;
        end else begin
            f_q      <= f_d;
            status_q <= status_d;
        end
    end

    assign f      = f_q;
    assign status = status_q;

endmodule

// File: tb/tb_arm_alu.sv
// tb_arm_alu: directed literal checks plus randomized stimulus against an
// arithmetic reference model; every cycle's output is compared.
module tb_arm_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fs;
    logic [63:0] a, b;
    logic [63:0] f;
    logic [3:0]  status;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_f;
    logic [3:0]  exp_s;
    bit          exp_vld = 0;
    bit          done    = 0;

    arm_alu #(.WIDTH(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .fs     (fs),
        .a      (a),
        .b      (b),
        .f      (f),
        .status (status)
    );

    always #5 clk = ~clk;

    // Reference model: plain unsigned / signed arithmetic on widened values.
    function automatic void model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                                  output logic [63:0] r, output logic [3:0] s);
        logic [64:0] wide;
        logic signed [64:0] sx, sy, sr;
        logic c, v;
        c = 0; v = 0;
        sx = $signed({x[63], x});
        sy = $signed({y[63], y});
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: begin
                wide = {1'b0, x} + {1'b0, y};
                r = wide[63:0];
                c = wide[64];
                sr = sx + sy;
                v = (sr > 65'sd9223372036854775807) || (sr < -65'sd9223372036854775808);
            end
            4'b0110: begin
                r = x - y;
                c = (x >= y);
                sr = sx - sy;
                v = (sr > 65'sd9223372036854775807) || (sr < -65'sd9223372036854775808);
            end
            4'b0111: r = y;
            4'b1100: r = ~(x | y);
            default: r = 64'd0;
        endcase
        s = {r[63], (r == 64'd0), c, v};
    endfunction

    task automatic chk(input string name, input logic [63:0] af, input logic [63:0] ef,
                       input logic [3:0] as_, input logic [3:0] es);
        checks++;
        if (af !== ef || as_ !== es) begin
            failures++;
            $display("FAIL %s: got f=%h status=%b, expected f=%h status=%b", name, af, as_, ef, es);
        end
    endtask

    // Model tracks what the registers must hold after each edge.
    always @(posedge clk) begin
        if (reset) begin
            exp_f = 64'd0;
            exp_s = 4'b0000;
        end else begin
            model(fs, a, b, exp_f, exp_s);
        end
        exp_vld = 1;
    end

    always @(negedge clk) begin
        if (exp_vld && !done) chk("cycle_model", f, exp_f, status, exp_s);
    end

    // Apply inputs, take one edge, and check against a literal expectation.
    task automatic step(input string name, input logic [3:0] op, input logic [63:0] x,
                        input logic [63:0] y, input logic [63:0] ef, input logic [3:0] es);
        fs = op; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        chk(name, f, ef, status, es);
        #1;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [3:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0111;
            5: return 4'b1100;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] PA   = 64'hF0F0_F0F0_F0F0_F0F0;
    localparam logic [63:0] PB   = 64'hFF00_FF00_FF00_FF00;

    initial begin
        reset = 1; fs = 4'b0010; a = ONES; b = ONES;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("reset", f, 64'd0, status, 4'b0000);
        #1;
        reset = 0;
        step("post_reset_add", 4'b0010, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010);

        step("and",   4'b0000, PA, PB, 64'hF000_F000_F000_F000, 4'b1000);
        step("or",    4'b0001, PA, PB, 64'hFFF0_FFF0_FFF0_FFF0, 4'b1000);
        step("nor",   4'b1100, PA, PB, 64'h000F_000F_000F_000F, 4'b0000);
        step("passb", 4'b0111, PA, PB, PB, 4'b1000);

        step("add_small", 4'b0010, 64'd3, 64'd3, 64'd6, 4'b0000);
        step("sub_eq",    4'b0110, 64'd3, 64'd3, 64'd0, 4'b0110);
        step("sub_borrow",4'b0110, 64'd3, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 4'b1000);

        step("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001);
        step("sub_ovf", 4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
        step("add_wrap", 4'b0010, ONES, 64'd1, 64'd0, 4'b0110);
        step("reserved_0011", 4'b0011, ONES, ONES, 64'd0, 4'b0100);
        step("reserved_1111", 4'b1111, 64'd5, 64'd7, 64'd0, 4'b0100);

        // Reset in flight discards the pending op.
        fs = 4'b0001; a = 64'h1234; b = 64'h5678; reset = 1;
        @(posedge clk); @(negedge clk);
        chk("reset_midstream", f, 64'd0, status, 4'b0000);
        #1; reset = 0;
        step("after_reset_or", 4'b0001, 64'h1234, 64'h5678, 64'h567C, 4'b0000);

        // Random back-to-back traffic, occasional reset; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            fs = pick_op(); a = pick(); b = pick();
            @(posedge clk);
            @(negedge clk);
            #1;
        end

        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
